// File: rtl/digital_clock_top.sv
// 24-hour BCD clock with time preset, HH:MM alarm and an 8-digit multiplexed 7-segment scan.
// Optional ALARM_BLINK_EN: the alarm output toggles on each second tick during the matching minute.
module digital_clock_top #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_time_finish,
    input  logic [3:0] set_sec_ge,
    input  logic [2:0] set_sec_shi,
    input  logic [3:0] set_min_ge,
    input  logic [2:0] set_min_shi,
    input  logic [3:0] set_hour_ge,
    input  logic [1:0] set_hour_shi,
    input  logic       clock_en,
    input  logic [3:0] clock_min_ge,
    input  logic [2:0] clock_min_shi,
    input  logic [3:0] clock_hour_ge,
    input  logic [1:0] clock_hour_shi,
    output logic       clock_out,
    output logic [3:0] sec_ge_r,
    output logic [2:0] sec_shi_r,
    output logic [3:0] min_ge_r,
    output logic [2:0] min_shi_r,
    output logic [3:0] hour_ge_r,
    output logic [1:0] hour_shi_r,
    output logic [7:0] data_out,
    output logic [7:0] select
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_cnt;
    logic          tick;

    assign tick = (presc_cnt == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            presc_cnt <= '0;
        end else if (set_time_finish || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    logic set_valid;
    logic sec_ge_max, sec_max, min_ge_max, min_max, hour_max;

    assign set_valid = (set_sec_ge <= 4'd9) && (set_sec_shi <= 3'd5) &&
                       (set_min_ge <= 4'd9) && (set_min_shi <= 3'd5) &&
                       (set_hour_ge <= 4'd9) && (set_hour_shi <= 2'd2) &&
                       !((set_hour_shi == 2'd2) && (set_hour_ge > 4'd3));

    assign sec_ge_max = (sec_ge_r == 4'd9);
    assign sec_max    = sec_ge_max && (sec_shi_r == 3'd5);
    assign min_ge_max = (min_ge_r == 4'd9);
    assign min_max    = min_ge_max && (min_shi_r == 3'd5);
    assign hour_max   = (hour_shi_r == 2'd2) && (hour_ge_r == 4'd3);

    // An out-of-range preset is dropped as a whole so the time never holds a non-BCD value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sec_ge_r   <= '0;
            sec_shi_r  <= '0;
            min_ge_r   <= '0;
            min_shi_r  <= '0;
            hour_ge_r  <= '0;
            hour_shi_r <= '0;
        end else if (set_time_finish) begin
            if (set_valid) begin
                sec_ge_r   <= set_sec_ge;
                sec_shi_r  <= set_sec_shi;
                min_ge_r   <= set_min_ge;
                min_shi_r  <= set_min_shi;
                hour_ge_r  <= set_hour_ge;
                hour_shi_r <= set_hour_shi;
            end
        end else if (tick) begin
            sec_ge_r <= sec_ge_max ? 4'd0 : sec_ge_r + 4'd1;
            if (sec_ge_max) begin
                sec_shi_r <= (sec_shi_r == 3'd5) ? 3'd0 : sec_shi_r + 3'd1;
            end
            if (sec_max) begin
                min_ge_r <= min_ge_max ? 4'd0 : min_ge_r + 4'd1;
            end
            if (sec_max && min_ge_max) begin
                min_shi_r <= (min_shi_r == 3'd5) ? 3'd0 : min_shi_r + 3'd1;
            end
            if (sec_max && min_max) begin
                if (hour_max) begin
                    hour_ge_r  <= 4'd0;
                    hour_shi_r <= 2'd0;
                end else if (hour_ge_r == 4'd9) begin
                    hour_ge_r  <= 4'd0;
                    hour_shi_r <= hour_shi_r + 2'd1;
                end else begin
                    hour_ge_r <= hour_ge_r + 4'd1;
                end
            end
        end
    end

    logic alarm_hit;

    assign alarm_hit = clock_en &&
                       (hour_shi_r == clock_hour_shi) && (hour_ge_r == clock_hour_ge) &&
                       (min_shi_r == clock_min_shi) && (min_ge_r == clock_min_ge);

`ifdef ALARM_BLINK_EN
    logic alarm_hit_d;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            clock_out   <= 1'b0;
            alarm_hit_d <= 1'b0;
        end else begin
            alarm_hit_d <= alarm_hit;
            if (!alarm_hit) begin
                clock_out <= 1'b0;
            end else if (!alarm_hit_d) begin
                clock_out <= 1'b1;
            end else if (tick) begin
                clock_out <= ~clock_out;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst_n) begin
            clock_out <= 1'b0;
        end else begin
            clock_out <= alarm_hit;
        end
    end
`endif

    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit_idx;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] val);
        case (val)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    logic [3:0] digit_val;
    logic       digit_dash;

    always_comb begin
        digit_val  = 4'd0;
        digit_dash = 1'b0;
        case (digit_idx)
            3'd0:    digit_val  = sec_ge_r;
            3'd1:    digit_val  = {1'b0, sec_shi_r};
            3'd2:    digit_dash = 1'b1;
            3'd3:    digit_val  = min_ge_r;
            3'd4:    digit_val  = {1'b0, min_shi_r};
            3'd5:    digit_dash = 1'b1;
            3'd6:    digit_val  = hour_ge_r;
            default: digit_val  = {2'b00, hour_shi_r};
        endcase
    end

    // Select and pattern share one register stage so they always switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            select   <= 8'hFF;
            data_out <= 8'hFF;
        end else begin
            select   <= ~(8'h01 << digit_idx);
            data_out <= digit_dash ? 8'hBF : seg_code(digit_val);
        end
    end

endmodule

// File: tb/tb_digital_clock_top.sv
// Directed bench for digital_clock_top with CLK_FREQ=10 and SCAN_DIV=4.
module tb_digital_clock_top;

    localparam int CLK_FREQ = 10;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set_time_finish;
    logic [3:0] set_sec_ge;
    logic [2:0] set_sec_shi;
    logic [3:0] set_min_ge;
    logic [2:0] set_min_shi;
    logic [3:0] set_hour_ge;
    logic [1:0] set_hour_shi;
    logic       clock_en;
    logic [3:0] clock_min_ge;
    logic [2:0] clock_min_shi;
    logic [3:0] clock_hour_ge;
    logic [1:0] clock_hour_shi;
    logic       clock_out;
    logic [3:0] sec_ge_r;
    logic [2:0] sec_shi_r;
    logic [3:0] min_ge_r;
    logic [2:0] min_shi_r;
    logic [3:0] hour_ge_r;
    logic [1:0] hour_shi_r;
    logic [7:0] data_out;
    logic [7:0] select;

    int n_cmp = 0;
    int n_err = 0;

    digital_clock_top #(.CLK_FREQ(CLK_FREQ), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .set_time_finish(set_time_finish),
        .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
        .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
        .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
        .clock_en(clock_en), .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
        .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
        .clock_out(clock_out),
        .sec_ge_r(sec_ge_r), .sec_shi_r(sec_shi_r), .min_ge_r(min_ge_r),
        .min_shi_r(min_shi_r), .hour_ge_r(hour_ge_r), .hour_shi_r(hour_shi_r),
        .data_out(data_out), .select(select)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected time given as 24'hHHMMSS.
    task automatic check_time(input string tag, input logic [23:0] exp);
        check(tag, {8'h0, 2'b00, hour_shi_r, hour_ge_r, 1'b0, min_shi_r, min_ge_r,
                    1'b0, sec_shi_r, sec_ge_r}, {8'h0, exp});
    endtask

    task automatic load_set(input logic [23:0] t);
        set_hour_shi = t[21:20];
        set_hour_ge  = t[19:16];
        set_min_shi  = t[14:12];
        set_min_ge   = t[11:8];
        set_sec_shi  = t[6:4];
        set_sec_ge   = t[3:0];
    endtask

    logic [7:0] exp_sel  [8];
    logic [7:0] exp_data [8];

    initial begin
        exp_sel  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        exp_data = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};

        rst_n = 1'b1;
        set_time_finish = 1'b0;
        load_set(24'h000000);
        clock_en = 1'b0;
        clock_hour_shi = 2'd0;
        clock_hour_ge  = 4'd0;
        clock_min_shi  = 3'd0;
        clock_min_ge   = 4'd0;

        step(5);
        check_time("reset_time", 24'h000000);
        check("reset_clock_out", {31'h0, clock_out}, 32'h0);
        check("reset_select", {24'h0, select}, 32'hFF);
        check("reset_data_out", {24'h0, data_out}, 32'hFF);
        rst_n = 1'b0;

        step(9);
        check_time("before_first_tick", 24'h000000);
        step(1);
        check_time("first_tick", 24'h000001);

        // Preset just before midnight and roll through it.
        load_set(24'h235958);
        set_time_finish = 1'b1;
        step(1);
        set_time_finish = 1'b0;
        check_time("preset_235958", 24'h235958);
        step(9);
        check_time("tick_gap_after_set", 24'h235958);
        step(1);
        check_time("to_235959", 24'h235959);
        step(10);
        check_time("midnight_wrap", 24'h000000);

        // Held set freezes time; scan the display while it is frozen.
        load_set(24'h123456);
        set_time_finish = 1'b1;
        step(35);
        check_time("set_held_frozen", 24'h123456);

        begin
            int guard = 0;
            while (select !== 8'hFE && guard < 50) begin
                step(1);
                guard++;
            end
            check("scan_find_digit0", {31'h0, guard < 50}, 32'h1);
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan_select_%0d", k), {24'h0, select}, {24'h0, exp_sel[k]});
            check($sformatf("scan_data_%0d", k), {24'h0, data_out}, {24'h0, exp_data[k]});
            step(SCAN_DIV);
        end
        check("scan_wraps_to_0", {24'h0, select}, 32'hFE);

        load_set(24'h250000);
        step(3);
        check_time("invalid_hour_25", 24'h123456);
        load_set(24'h240000);
        step(3);
        check_time("invalid_hour_24", 24'h123456);
        load_set(24'h10000A);
        step(3);
        check_time("invalid_sec_ge", 24'h123456);
        set_time_finish = 1'b0;
        step(9);
        check_time("resume_hold", 24'h123456);
        step(1);
        check_time("resume_tick", 24'h123457);

        // Alarm at 00:01.
        clock_en = 1'b1;
        clock_min_ge = 4'd1;
        load_set(24'h000059);
        set_time_finish = 1'b1;
        step(1);
        set_time_finish = 1'b0;
        check("alarm_idle", {31'h0, clock_out}, 32'h0);
        step(10);
        check_time("alarm_minute_reached", 24'h000100);
        check("alarm_not_yet", {31'h0, clock_out}, 32'h0);
        step(1);
        check("alarm_rise", {31'h0, clock_out}, 32'h1);
`ifdef ALARM_BLINK_EN
        step(9);
        check("blink_off", {31'h0, clock_out}, 32'h0);
        step(10);
        check("blink_on", {31'h0, clock_out}, 32'h1);
        step(580);
`else
        step(300);
        check("alarm_mid_minute", {31'h0, clock_out}, 32'h1);
        step(299);
`endif
        check_time("alarm_minute_end", 24'h000200);
        check("alarm_last_cycle", {31'h0, clock_out}, 32'h1);
        step(1);
        check("alarm_fall", {31'h0, clock_out}, 32'h0);

        clock_en = 1'b0;
        load_set(24'h000059);
        set_time_finish = 1'b1;
        step(1);
        set_time_finish = 1'b0;
        step(15);
        check_time("disabled_match_time", 24'h000100);
        check("alarm_disabled", {31'h0, clock_out}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digital_clock_top.md
Name: digital_clock_top

Overview:
- 24-hour BCD digital clock with time preset, an hour:minute alarm, and an 8-digit multiplexed 7-segment driver.
- Top level of the clock design; it sits directly between the board clock, switches/keys, the buzzer and the LED display.
- A prescaler produces a 1 Hz tick that advances the HH:MM:SS counters.
- The current time is exported as BCD digits and scanned onto the display.

Parameters:
- CLK_FREQ, 50_000_000: clk cycles per second tick (a small value is used in simulation).
- SCAN_DIV, 50_000: clk cycles each display digit stays selected.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-high reset. The port name is kept for codebase consistency; 1 means reset.
- set_time_finish  in  1  level; while high, the set_* values are loaded into the time counters.
- set_sec_ge  in  4  preset seconds units (0-9).
- set_sec_shi  in  3  preset seconds tens (0-5).
- set_min_ge  in  4  preset minutes units.
- set_min_shi  in  3  preset minutes tens.
- set_hour_ge  in  4  preset hours units.
- set_hour_shi  in  2  preset hours tens (0-2).
- clock_en  in  1  alarm enable.
- clock_min_ge  in  4  alarm minutes units.
- clock_min_shi  in  3  alarm minutes tens.
- clock_hour_ge  in  4  alarm hours units.
- clock_hour_shi  in  2  alarm hours tens.
- clock_out  out  1  alarm/buzzer output, registered.
- sec_ge_r  out  4  current seconds units.
- sec_shi_r  out  3  current seconds tens.
- min_ge_r  out  4  current minutes units.
- min_shi_r  out  3  current minutes tens.
- hour_ge_r  out  4  current hours units.
- hour_shi_r  out  2  current hours tens.
- data_out  out  8  segment pattern, active-low, bit order {dp,g,f,e,d,c,b,a}.
- select  out  8  digit enable, active-low one-hot; bit i selects digit i.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - all time digits 0; prescaler 0; scan counter and digit index 0;
  - clock_out=0; data_out=8'hFF; select=8'hFF.
- Prescaler:
  - counts 0..CLK_FREQ-1 and wraps;
  - tick is asserted for the single cycle in which the count equals CLK_FREQ-1.
- On tick the time increments by one second, and the new value is visible the cycle after the tick.
  - sec_ge rolls 9->0 and carries to sec_shi; sec_shi rolls 5->0 and carries to minutes.
  - Minutes roll the same way and carry to hours.
  - Hours: hour_ge 9->0 with hour_shi+1; 23 rolls to 00.
  - 23:59:59 + tick = 00:00:00.
- Set:
  - While set_time_finish=1, every cycle loads all six set_* digits and clears the prescaler.
  - Set has priority over tick.
  - Counting resumes from the loaded value; the first tick arrives CLK_FREQ cycles after set_time_finish falls.
- Invalid set:
  - Any digit out of range (ge>9, sec/min shi>5, hour_shi>2, or hour_shi=2 with hour_ge>3) causes the whole load to be ignored that cycle.
  - Time is held and the prescaler is still cleared.
- Alarm:
  - clock_out is registered: clock_en & (hour_shi,hour_ge,min_shi,min_ge == clock_* values).
  - It is therefore high for the whole matching minute and drops one cycle after the match ends or clock_en falls.
- Display scan:
  - The digit index advances 0->7->0 every SCAN_DIV cycles.
  - select and data_out are registered together, so the digit and its pattern change on the same edge.
  - Digit map: 7=hour_shi, 6=hour_ge, 5=dash, 4=min_shi, 3=min_ge, 2=dash, 1=sec_shi, 0=sec_ge.
- Segment codes:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, dash BF.
  - Any other value is blank, FF.
- The time outputs are direct register values.

Optional Feature:
- ALARM_BLINK_EN defined: during an alarm match, clock_out toggles on each tick, giving a 0.5 Hz on/off pattern.
  - It is forced 0 when there is no match.
  - The toggle starts at 1 on the first cycle of the match.
- Not defined: clock_out is steady high during the match, as described in Behaviour.

Test Plan:
- Reset held 5 cycles, CLK_FREQ=10, SCAN_DIV=4 -> all time outputs 0, clock_out=0, select=FF, data_out=FF; after release the first tick occurs at cycle 10 and sec_ge=1.
- Set 23:59:58 with set_time_finish pulsed 1 cycle -> the outputs show 23:59:58; after 2 ticks the outputs show 00:00:00.
- set_time_finish held high across several tick periods -> time stays frozen at the set value; set 25:00:00 -> the load is ignored and time is unchanged.
- clock_en=1 with alarm 00:01, time preset 00:00:59 -> clock_out rises one cycle after the minute reaches 01, stays high 60 ticks, then falls at 00:02:00; clock_en=0 -> it stays 0.
- Time 12:34:56 -> over 8*SCAN_DIV cycles select walks FE,FD,...,7F with data_out 82,92,BF,99,B0,BF,A4,F9.
- With ALARM_BLINK_EN defined -> clock_out alternates on each tick during the matching minute.
